panda_alu_arbiter: RTL
======================

PANDA_ALU_ARBITER -- requirements
Module: panda_alu_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one ALU (legal 2..8).
REQ-002 SHALL have derived parameter IdWidth, default $clog2(NumReq), width of requester index.
REQ-003 SHALL have port clk_i, input, 1, the only clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i, input, NumReq, request valid per requester.
REQ-006 SHALL have port req_ready_o, output, NumReq, request accepted this cycle per requester.
REQ-007 SHALL have port req_operator_i, input, NumReq x alu_operator_e, ALU operation per requester.
REQ-008 SHALL have port req_operand_a_i, input, NumReq x 32, operand A per requester.
REQ-009 SHALL have port req_operand_b_i, input, NumReq x 32, operand B per requester.
REQ-010 SHALL have port rsp_valid_o, output, 1, result register holds valid result.
REQ-011 SHALL have port rsp_ready_i, input, 1, consumer takes result this cycle.
REQ-012 SHALL have port rsp_id_o, output, IdWidth, index of requester owning result.
REQ-013 SHALL have port rsp_result_o, output, 32, registered ALU result.

Function
REQ-014 SHALL pass the selected requester's operator/operands to one panda_alu instance; no ALU per requester.
REQ-015 SHALL hold a one-entry output buffer with states EMPTY and FULL.
REQ-016 SHALL treat the output slot as free when the buffer is EMPTY, or FULL with rsp_ready_i=1 (same-cycle drain and refill).
REQ-017 SHALL, when the slot is free and any req_valid_i bit is set, grant exactly one requester via round-robin: search starts at last_grant+1, wraps modulo NumReq.
REQ-018 SHALL drive req_ready_o one-hot for the granted requester only, zero when no grant; req_ready_o[i] never high while req_valid_i[i]=0.
REQ-019 SHALL define a transfer as req_valid_i[i] & req_ready_o[i]; requesters hold valid and operands stable until transfer.
REQ-020 SHALL, on transfer in cycle N, register ALU result and grant index; rsp_valid_o=1 in cycle N+1 (latency 1).
REQ-021 SHALL update last_grant only on transfer; unaccepted requests do not move priority.
REQ-022 SHALL transition EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready_i without transfer; FULL->FULL on simultaneous drain and transfer (new result replaces old).
REQ-023 SHALL hold rsp_result_o and rsp_id_o stable while FULL and rsp_ready_i=0.
REQ-024 SHALL sustain one result per cycle with rsp_ready_i held high.
REQ-025 SHALL guarantee any continuously valid requester a transfer within NumReq slot-free cycles.
REQ-026 SHALL ignore rsp_ready_i while EMPTY.

Reset
REQ-027 SHALL, asynchronously on rst_ni low, force state EMPTY, rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0, last_grant=NumReq-1 (requester 0 first priority).
REQ-028 SHALL drop any buffered result on reset mid-operation; req_ready_o=0 throughout reset.

Structure
REQ-029 SHALL reuse alu_operator_e from panda_pkg and add alu_req_t (operator, operand_a, operand_b) plus arb_state_e {ARB_EMPTY, ARB_FULL} to panda_pkg.
REQ-030 SHALL instantiate panda_alu as its only sub-module; round-robin logic inline.

Verification
REQ-031 Reset: rst_ni low mid-FULL -> rsp_valid_o=0, req_ready_o=0 immediately; first grant after release to requester 0.
REQ-032 Single: req 1 valid, ALU_ADD, A=30, B=3 -> req_ready_o=2'b10 same cycle; next cycle rsp_valid_o=1, rsp_id_o=1, rsp_result_o=33.
REQ-033 Contention: both valid continuously, req0 ALU_ADD 30+50, req1 ALU_SUB 30-50, rsp_ready_i=1 -> ids alternate 0,1,0,1; results 80, -20 (32'hFFFFFFEC); one per cycle.
REQ-034 Backpressure: FULL with result 33, rsp_ready_i=0 for 3 cycles, req 0 valid -> req_ready_o=0, rsp_result_o stays 33; on rsp_ready_i=1, req 0 granted same cycle, new result next cycle.
REQ-035 Priority hold: req1 valid but blocked by backpressure, last_grant=0 -> after drain, req1 granted before req0.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types for the panda ALU slice.
//   alu_operator_e : operation encoding understood by panda_alu
//   alu_req_t      : one ALU request (operator plus both operands)
//   arb_state_e    : occupancy of the arbiter's one-entry result buffer
package panda_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_operator_e;

  typedef struct packed {
    alu_operator_e        operator;
    logic [DataWidth-1:0] operand_a;
    logic [DataWidth-1:0] operand_b;
  } alu_req_t;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/panda_alu.sv
// Purely combinational 32-bit integer ALU.
// Ports:
//   operator_i  : operation select (alu_operator_e)
//   operand_a_i : first operand
//   operand_b_i : second operand; only bits [4:0] are used as shift amount
//   result_o    : result; compares return 0/1 zero-extended
module panda_alu
  import panda_pkg::*;
(
  input  alu_operator_e        operator_i,
  input  logic [DataWidth-1:0] operand_a_i,
  input  logic [DataWidth-1:0] operand_b_i,
  output logic [DataWidth-1:0] result_o
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = operand_b_i[4:0];
  assign lt_signed   = $signed(operand_a_i) < $signed(operand_b_i);
  assign lt_unsigned = operand_a_i < operand_b_i;

  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt;
      ALU_SRL:  result_o = operand_a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(operand_a_i) >>> shamt);
      ALU_SLT:  result_o = {{(DataWidth-1){1'b0}}, lt_signed};
      ALU_SLTU: result_o = {{(DataWidth-1){1'b0}}, lt_unsigned};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/panda_alu_arbiter.sv
// Round-robin arbiter sharing one panda_alu among NumReq requesters, with a
// one-entry registered result buffer (latency 1, one result per cycle).
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   req_valid_i       : per-requester request valid
//   req_ready_o       : one-hot grant, high in the cycle the request is taken
//   req_operator_i    : per-requester ALU operation
//   req_operand_a_i/b : per-requester operands
//   rsp_valid_o       : result buffer holds a result
//   rsp_ready_i       : consumer takes the result this cycle
//   rsp_id_o          : requester index owning the buffered result
//   rsp_result_o      : buffered ALU result
module panda_alu_arbiter
  import panda_pkg::*;
#(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdWidth = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  alu_operator_e        req_operator_i  [NumReq],
  input  logic [DataWidth-1:0] req_operand_a_i [NumReq],
  input  logic [DataWidth-1:0] req_operand_b_i [NumReq],
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdWidth-1:0]   rsp_id_o,
  output logic [DataWidth-1:0] rsp_result_o
);

  arb_state_e           state_q, state_d;
  logic [IdWidth-1:0]   last_grant_q;
  logic [IdWidth-1:0]   id_q;
  logic [DataWidth-1:0] result_q;

  logic                 slot_free;
  logic                 grant_valid;
  logic [IdWidth-1:0]   grant_idx;
  logic [NumReq-1:0]    above_last;
  logic [NumReq-1:0]    masked_valid;
  logic [NumReq-1:0]    pick_vec;
  alu_req_t             sel_req;
  logic [DataWidth-1:0] alu_result;

  // A full buffer still counts as free when it drains this cycle.
  assign slot_free = (state_q == ARB_EMPTY) || rsp_ready_i;

  // Gated by rst_ni so no grant is ever visible while reset is asserted.
  assign grant_valid = slot_free && (|req_valid_i) && rst_ni;

  // Round-robin: prefer requesters above last_grant, else wrap to the lowest.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < NumReq; i++) begin
      above_last[i] = IdWidth'(i) > last_grant_q;
    end
  end

  assign masked_valid = req_valid_i & above_last;
  assign pick_vec     = (|masked_valid) ? masked_valid : req_valid_i;

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    grant_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        grant_idx = IdWidth'(i);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = grant_valid && (grant_idx == IdWidth'(i));
    end
  end

  // Operand mux feeding the single shared ALU.
  always_comb begin
    sel_req = '{operator:  req_operator_i[0],
                operand_a: req_operand_a_i[0],
                operand_b: req_operand_b_i[0]};
    for (int i = 1; i < NumReq; i++) begin
      if (grant_idx == IdWidth'(i)) begin
        sel_req = '{operator:  req_operator_i[i],
                    operand_a: req_operand_a_i[i],
                    operand_b: req_operand_b_i[i]};
      end
    end
  end

  panda_alu u_alu (
    .operator_i  (sel_req.operator),
    .operand_a_i (sel_req.operand_a),
    .operand_b_i (sel_req.operand_b),
    .result_o    (alu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_EMPTY: begin
        if (grant_valid) begin
          state_d = ARB_FULL;
        end
      end
      ARB_FULL: begin
        if (grant_valid) begin
          state_d = ARB_FULL;
        end else if (rsp_ready_i) begin
          state_d = ARB_EMPTY;
        end
      end
      default: state_d = ARB_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_EMPTY;
      last_grant_q <= IdWidth'(NumReq - 1);
      id_q         <= '0;
      result_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        last_grant_q <= grant_idx;
        id_q         <= grant_idx;
        result_q     <= alu_result;
      end
    end
  end

  assign rsp_valid_o  = (state_q == ARB_FULL);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;

endmodule
